// File: rtl/i2s_frame_read_scheduler.sv
// Round-robin scheduler that streams whole 256-bit frames out of the I2S capture RAM
// to two requesters, reporting ok/stale/empty/overrun for each transaction.
module i2s_frame_read_scheduler #(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                     clk_x4_i,
  input  logic                     rst_n_i,
  input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
  input  logic [1:0]               req_i,
  output logic [1:0]               gnt_o,
  output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
  output logic                     ram_read_en_o,
  input  logic                     ram_read_data_i,
  output logic                     bit_valid_o,
  output logic                     bit_data_o,
  output logic                     done_o,
  output logic [1:0]               status_o
);

  localparam int FW = CIRC_BUF_BITS;
  localparam logic [FW-1:0] FRAME_ONE = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_STALE = 2'b01;
  localparam logic [1:0] ST_EMPTY = 2'b10;
  localparam logic [1:0] ST_OVR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_r;
  logic [FW-1:0] frame_r;
  logic [FW-1:0] prev_idx_r;
  logic [FW-1:0] rec_r [2];
  logic [7:0]    bit_cnt_r;
  logic          frame_seen_r;
  logic          prio_r;
  logic          owner_r;
  logic          upd_r;
  logic          stale_r;
  logic [1:0]    mask_r;

  logic [1:0]    req_eff_s;
  logic          win_s;
  logic          win_stale_s;
  logic          ovr_s;
  logic          own_req_s;

  // Arbitration winner, overrun detection and owner request level
  always_comb begin
    req_eff_s = req_i & ~mask_r;
    ovr_s     = (last_good_frame_idx_i == (frame_r - FRAME_ONE));
    own_req_s = owner_r ? req_i[1] : req_i[0];
    if (req_i == 2'b11) begin
      win_s = prio_r;
    end else if (req_i[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    win_stale_s = (last_good_frame_idx_i == rec_r[win_s]);
  end

  // Data passes straight through in the cycle after the strobe; gated to 0 otherwise
  assign bit_data_o = bit_valid_o & ram_read_data_i;

  // Transaction FSM with registered outputs
  always_ff @(posedge clk_x4_i) begin
    if (!rst_n_i) begin
      state_r         <= IDLE;
      gnt_o           <= 2'b00;
      ram_read_en_o   <= 1'b0;
      ram_read_addr_o <= '0;
      bit_valid_o     <= 1'b0;
      done_o          <= 1'b0;
      status_o        <= 2'b00;
      frame_r         <= '0;
      prev_idx_r      <= last_good_frame_idx_i;
      rec_r[0]        <= '0;
      rec_r[1]        <= '0;
      bit_cnt_r       <= 8'd0;
      frame_seen_r    <= 1'b0;
      prio_r          <= 1'b0;
      owner_r         <= 1'b0;
      upd_r           <= 1'b0;
      stale_r         <= 1'b0;
      mask_r          <= 2'b00;
    end else begin
      prev_idx_r   <= last_good_frame_idx_i;
      frame_seen_r <= frame_seen_r | (last_good_frame_idx_i != prev_idx_r);
      case (state_r)
        IDLE: begin
          mask_r <= 2'b00;
          if (req_eff_s != 2'b00) begin
            state_r <= ARB;
          end
        end
        ARB: begin
          if (req_i == 2'b00) begin
            state_r <= IDLE;
          end else begin
            owner_r <= win_s;
            prio_r  <= ~win_s;
            gnt_o   <= win_s ? 2'b10 : 2'b01;
            frame_r <= last_good_frame_idx_i;
            stale_r <= win_stale_s;
            if (!frame_seen_r) begin
              upd_r    <= 1'b0;
              done_o   <= 1'b1;
              status_o <= ST_EMPTY;
              state_r  <= DONE;
            end else begin
              upd_r           <= 1'b1;
              bit_cnt_r       <= 8'd0;
              ram_read_en_o   <= 1'b1;
              ram_read_addr_o <= {last_good_frame_idx_i, 8'h00};
              state_r         <= READ;
            end
          end
        end
        READ: begin
          if (ovr_s) begin
            ram_read_en_o <= 1'b0;
            bit_valid_o   <= 1'b0;
            done_o        <= 1'b1;
            status_o      <= ST_OVR;
            state_r       <= DONE;
          end else if (!own_req_s) begin
            ram_read_en_o <= 1'b0;
            bit_valid_o   <= 1'b0;
            upd_r         <= 1'b0;
            done_o        <= 1'b1;
            status_o      <= ST_OK;
            state_r       <= DONE;
          end else begin
            bit_valid_o <= 1'b1;
            // Terminal count ends the burst; the counter never needs to wrap
            if (bit_cnt_r == 8'hFF) begin
              ram_read_en_o <= 1'b0;
              state_r       <= DRAIN;
            end else begin
              bit_cnt_r       <= bit_cnt_r + 8'd1;
              ram_read_addr_o <= {frame_r, bit_cnt_r + 8'd1};
            end
          end
        end
        DRAIN: begin
          bit_valid_o <= 1'b0;
          done_o      <= 1'b1;
          state_r     <= DONE;
          if (ovr_s) begin
            status_o <= ST_OVR;
          end else begin
            status_o <= stale_r ? ST_STALE : ST_OK;
          end
        end
        DONE: begin
          done_o   <= 1'b0;
          status_o <= 2'b00;
          gnt_o    <= 2'b00;
          mask_r   <= gnt_o;
          if (upd_r) begin
            rec_r[owner_r] <= frame_r;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r       <= IDLE;
          gnt_o         <= 2'b00;
          ram_read_en_o <= 1'b0;
          bit_valid_o   <= 1'b0;
          done_o        <= 1'b0;
          status_o      <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_frame_read_scheduler.sv
// Self-checking bench: directed scenarios plus randomized frames against a transaction-level model.
module tb_i2s_frame_read_scheduler;

  localparam int CB = 3;

  logic          clk_x4_i = 1'b0;
  logic          rst_n_i;
  logic [CB-1:0] last_good;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [CB+7:0] addr;
  logic          ren;
  logic          rdata;
  logic          bv;
  logic          bd;
  logic          done;
  logic [1:0]    status;

  logic mem [0:(1<<(CB+8))-1];

  int n_asrt = 0;
  int n_fail = 0;

  int         n_reads, n_valid, addr_bad, data_bad, first_rd;
  logic [1:0] got_gnt, got_st;
  logic       done_seen, rst_hit;

  logic          m_seen;
  logic [CB-1:0] m_rec [2];
  int            m_last;

  i2s_frame_read_scheduler #(.CIRC_BUF_BITS(CB)) dut (
    .clk_x4_i              (clk_x4_i),
    .rst_n_i               (rst_n_i),
    .last_good_frame_idx_i (last_good),
    .req_i                 (req),
    .gnt_o                 (gnt),
    .ram_read_addr_o       (addr),
    .ram_read_en_o         (ren),
    .ram_read_data_i       (rdata),
    .bit_valid_o           (bv),
    .bit_data_o            (bd),
    .done_o                (done),
    .status_o              (status)
  );

  always #5 clk_x4_i = ~clk_x4_i;

  // RAM with one cycle of read latency; junk on the data line when not read
  always @(posedge clk_x4_i) rdata <= ren ? mem[addr] : 1'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_seen   = 1'b0;
    m_rec[0] = '0;
    m_rec[1] = '0;
    m_last   = 1;
  endtask

  task automatic set_lg(input logic [CB-1:0] v);
    if (v != last_good) m_seen = 1'b1;
    last_good = v;
    repeat (3) @(negedge clk_x4_i);
  endtask

  // Who should win and what status should come back, from the rules alone
  task automatic model_txn(input logic [1:0] r, input bit ovr, output int w, output logic [1:0] st);
    if (r == 2'b11) w = 1 - m_last;
    else            w = r[1] ? 1 : 0;
    m_last = w;
    if (!m_seen)                   st = 2'b10;
    else if (ovr)                  st = 2'b11;
    else if (m_rec[w] == last_good) st = 2'b01;
    else                           st = 2'b00;
    if (m_seen) m_rec[w] = last_good;
  endtask

  task automatic run_txn(input int ovr_at, input logic [CB-1:0] ovr_val,
                         input logic [CB-1:0] exp_f, input int rst_at);
    n_reads = 0; n_valid = 0; addr_bad = 0; data_bad = 0; first_rd = -1;
    got_gnt = 2'b00; got_st = 2'b00; done_seen = 1'b0; rst_hit = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk_x4_i);
      if (gnt != 2'b00 && got_gnt == 2'b00) got_gnt = gnt;
      if (bv) begin
        if (bd !== mem[{exp_f, n_valid[7:0]}]) data_bad++;
        n_valid++;
      end
      if (ren) begin
        if (first_rd < 0) first_rd = c;
        if (addr !== {exp_f, n_reads[7:0]}) addr_bad++;
        if (n_reads == rst_at) begin
          rst_n_i = 1'b0;
          rst_hit = 1'b1;
          break;
        end
        if (n_reads == ovr_at) last_good = ovr_val;
        n_reads++;
      end
      if (done) begin
        done_seen = 1'b1;
        got_st    = status;
        break;
      end
    end
  endtask

  task automatic expect_txn(input string tag, input int w, input logic [1:0] st,
                            input int nr, input int nv);
    chk({tag, "_done"},  32'(done_seen), 32'd1);
    chk({tag, "_gnt"},   32'(got_gnt), (w == 1) ? 32'd2 : 32'd1);
    chk({tag, "_status"}, 32'(got_st), 32'(st));
    chk({tag, "_reads"}, n_reads, nr);
    chk({tag, "_valid"}, n_valid, nv);
    chk({tag, "_addr"},  addr_bad, 32'd0);
    chk({tag, "_data"},  data_bad, 32'd0);
  endtask

  initial begin
    int            w;
    logic [1:0]    st;
    logic [CB-1:0] v;
    logic [1:0]    r;
    int            oa;

    for (int i = 0; i < (1 << (CB + 8)); i++) mem[i] = 1'($urandom);
    rst_n_i = 1'b0; last_good = '0; req = 2'b00;
    model_reset();
    repeat (2) @(negedge clk_x4_i);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_en", 32'(ren), 32'd0);
    chk("rst_valid", 32'(bv), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_x4_i);
    chk("rel_quiet", 32'({ren, bv, done}), 32'd0);

    // No frame yet: empty, no reads
    model_txn(2'b01, 1'b0, w, st);
    req = 2'b01; run_txn(-1, '0, '0, -1); req = 2'b00;
    expect_txn("empty", w, st, 0, 0);
    repeat (3) @(negedge clk_x4_i);

    // First real frame, then an unchanged repeat
    set_lg(3'd2);
    model_txn(2'b01, 1'b0, w, st);
    req = 2'b01; run_txn(-1, '0, 3'd2, -1); req = 2'b00;
    expect_txn("frame2", w, st, 256, 256);
    chk("latency", first_rd, 32'd2);
    repeat (3) @(negedge clk_x4_i);
    model_txn(2'b01, 1'b0, w, st);
    req = 2'b01; run_txn(-1, '0, 3'd2, -1); req = 2'b00;
    expect_txn("stale", w, st, 256, 256);
    chk("stale_code", 32'(st), 32'd1);
    repeat (3) @(negedge clk_x4_i);

    // Fairness from reset with both held
    rst_n_i = 1'b0; @(negedge clk_x4_i); rst_n_i = 1'b1; model_reset();
    @(negedge clk_x4_i);
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      model_txn(2'b11, 1'b0, w, st);
      run_txn(-1, '0, '0, -1);
      expect_txn("rr", w, st, 0, 0);
      chk("rr_order", 32'(got_gnt), (t == 1) ? 32'd2 : 32'd1);
    end
    req = 2'b00;
    repeat (3) @(negedge clk_x4_i);

    // Writer laps into frame 5 at read 100
    set_lg(3'd5);
    model_txn(2'b10, 1'b1, w, st);
    req = 2'b10; run_txn(100, 3'd4, 3'd5, -1); req = 2'b00;
    expect_txn("ovr", w, st, 101, 100);
    chk("ovr_lt102", 32'(n_valid < 102), 32'd1);
    repeat (3) @(negedge clk_x4_i);

    // Reset mid-transaction at read 50
    set_lg(3'd6);
    req = 2'b01; run_txn(-1, '0, 3'd6, 50);
    chk("rst_hit", 32'(rst_hit), 32'd1);
    @(negedge clk_x4_i);
    chk("mid_rst_outs", 32'({gnt, ren, bv, bd, done, status}), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    rst_n_i = 1'b1; req = 2'b00; model_reset();
    @(negedge clk_x4_i);
    chk("mid_rel_quiet", 32'({ren, bv, done}), 32'd0);
    set_lg(3'd7);
    model_txn(2'b01, 1'b0, w, st);
    req = 2'b01; run_txn(-1, '0, 3'd7, -1); req = 2'b00;
    expect_txn("restart", w, st, 256, 256);
    repeat (3) @(negedge clk_x4_i);

    // Randomized frames, requesters and overrun points
    for (int k = 0; k < 8; k++) begin
      v  = CB'($urandom_range(0, (1 << CB) - 1));
      r  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      oa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 250)) : -1;
      set_lg(v);
      model_txn(r, oa >= 0, w, st);
      req = r; run_txn(oa, CB'(v - 1), v, -1); req = 2'b00;
      expect_txn("rnd", w, st, (oa >= 0) ? oa + 1 : 256, (oa >= 0) ? oa : 256);
      repeat (3) @(negedge clk_x4_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
